imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: the fetch stage only reads imem, and this block fills it.
- Accepts a byte stream (valid/ready, e.g. from a UART receiver) carrying a 16-bit word count followed by program words.
- Packs each 4 bytes into a 32-bit word and writes it into the imem write port at consecutive word addresses.
- Holds the CPU (forces PCWrite low / core held) until the load completes.

Parameters:
- ADDR_W, 11, imem word-address width; DEPTH = 2**ADDR_W words.
- HOLD_AT_RESET, 1, reset value of cpu_hold (1 = core boots stalled awaiting a load).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset. Asynchronous and active-high: asserting rst clears all state immediately, independent of clk.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte. A byte transfers when byte_valid & byte_ready.
- imem_addr  out  ADDR_W  imem write word address.
- imem_data  out  32  imem write data.
- imem_wren  out  1  one-cycle write strobe.
- cpu_hold  out  1  1 = core stalled.
- load_done  out  1  sticky successful-completion flag.
- load_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - state = IDLE.
  - byte_ready, imem_wren, load_done, load_err = 0.
  - imem_addr, imem_data = 0.
  - cpu_hold = HOLD_AT_RESET.
  - Byte counter, word counter and length register = 0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (only when the optional feature is enabled), DONE, ERR.
- IDLE: start -> LEN_LO; also clears load_done and load_err and sets cpu_hold = 1.
- byte_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in all other states.
- LEN_LO: accepted byte -> len[7:0]; go to LEN_HI.
- LEN_HI: accepted byte -> len[15:8]. Evaluated in the same cycle:
  - if {byte_in, len[7:0]} > DEPTH -> ERR;
  - else if it is 0 -> DONE (or CSUM when enabled);
  - else -> DATA.
- DATA packing:
  - Little-endian: the first byte of each group goes to bits [7:0], the fourth to bits [31:24].
  - A 2-bit byte counter wraps 3 -> 0.
- DATA write:
  - On acceptance of the 4th byte, in the next cycle: imem_wren = 1, imem_data = assembled word, imem_addr = word counter.
  - The word counter then increments, so write latency is 1 cycle after the 4th byte.
  - byte_ready stays 1 during the write cycle; the next byte may be accepted concurrently.
- DATA exit: when the written word's index == len-1 -> DONE (or CSUM when enabled), in the same cycle the final write is issued.
- Address wrap cannot occur, because len <= DEPTH is checked in LEN_HI.
- DONE: load_done = 1, cpu_hold = 0, byte_ready = 0.
- ERR: load_err = 1, cpu_hold = 1, byte_ready = 0; no further imem writes.
- start in DONE or ERR -> LEN_LO; clears both flags and reasserts cpu_hold.
- start in LEN_LO, LEN_HI, DATA or CSUM: ignored.
- byte_valid while byte_ready = 0: ignored, no state change.
- rst mid-load: load is abandoned and outputs return to their reset values. imem contents already written are not erased. A partial imem_wren pulse is never emitted after rst asserts.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Enabled: after the last data byte (or after LEN_HI when len = 0), the FSM enters CSUM and accepts one byte.
  - The byte is compared with the XOR of all previously accepted bytes, including both length bytes.
  - Match -> DONE; mismatch -> ERR.
  - Data words are already written to imem before the checksum is checked.
- Disabled: the CSUM state and the XOR register do not exist; DATA and zero-length loads go directly to DONE.

Decomposition:
- Package imem_loader_pkg contains:
  - state enum typedef (loader_state_t);
  - LEN_W = 16;
  - BYTES_PER_WORD = 4.
- One sub-module, word_packer: byte shift/assembly register plus 2-bit byte counter.
  - Inputs: clk, rst, clear, byte_in, byte_en.
  - Outputs: word[31:0], word_valid (1-cycle pulse).
- The top level holds the FSM, the word/address counter and the flags.

Test Plan:
- Basic load:
  - Stimulus: after rst, cpu_hold = 1; start; stream 02 00 | 13 00 00 00 | 6F 00 00 00.
  - Required: writes (addr 0, 0x00000013) then (addr 1, 0x0000006F), each one cycle after its 4th byte; load_done = 1, cpu_hold = 0.
- Backpressure gaps:
  - Stimulus: same stream with byte_valid low for 3 cycles between every byte.
  - Required: identical writes; no imem_wren while idle between bytes.
- Zero length:
  - Stimulus: start; stream 00 00.
  - Required: no imem_wren; DONE immediately after the LEN_HI byte.
- Oversize:
  - Stimulus: with ADDR_W = 11, stream len = 0x0801.
  - Required: ERR; load_err = 1; byte_ready = 0; cpu_hold = 1; further bytes produce no writes.
- Reset mid-load and reload:
  - Stimulus: rst during the 2nd byte of word 1 of a 3-word load; then start and a full 1-word load of 0xDEADBEEF.
  - Required: word 0 already written; after rst, outputs are at reset values; reload writes addr 0 = 0xDEADBEEF; load_done = 1.
- IMEM_LOADER_CSUM_EN:
  - Stimulus: stream 01 00 | 11 22 33 44 followed by checksum byte 0x45.
  - Required: DONE.
  - Stimulus: same stream followed by checksum byte 0x46.
  - Required: ERR, with the imem write to addr 0 already performed.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
`ifdef IMEM_LOADER_CSUM_EN
        ,
        CSUM   = 3'd6
`endif
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and pulses
// word_valid for one cycle after the fourth byte of each group.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] word_q,  word_d;
    logic        valid_q, valid_d;

    // Shifting in from the top leaves the first byte of a group in [7:0].
    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_en) begin
            word_d  = {byte_in, word_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Fills imem from a length-prefixed byte stream and holds the core until done.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = 11,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              imem_wren,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(1) << ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
    localparam loader_state_t AFTER_DATA = CSUM;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [ADDR_W-1:0] wcnt_q,  wcnt_d;
    logic              hold_q,  hold_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        xor_q,   xor_d;
`endif

    logic              accept;
    logic              last_word;
    logic              pk_clear;
    logic              pk_en;
    logic              word_valid;
    logic [31:0]       word;
    logic [LEN_W:0]    len_new;

    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            CSUM:                 byte_ready = 1'b1;
`endif
            default:              byte_ready = 1'b0;
        endcase
    end

    assign accept    = byte_valid & byte_ready;
    assign imem_wren = word_valid & (state_q == DATA);
    assign last_word = (LEN_W'(wcnt_q) == len_q - LEN_W'(1));
    assign len_new   = {1'b0, byte_in, len_q[7:0]};
    // A byte arriving alongside the final write is past the program data.
    assign pk_en     = accept & (state_q == DATA) & ~(imem_wren & last_word);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clear = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        xor_d    = accept ? (xor_q ^ byte_in) : xor_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = LEN_LO;
                    len_d    = '0;
                    wcnt_d   = '0;
                    hold_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    xor_d    = '0;
`endif
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d   = {len_q[LEN_W-1:8], byte_in};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = len_new[LEN_W-1:0];
                    if (len_new > DEPTH_L)    state_d = ERR;
                    else if (len_new == '0)   state_d = AFTER_DATA;
                    else                      state_d = DATA;
                end
            end
            DATA: begin
                if (imem_wren) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (last_word) begin
                        state_d = AFTER_DATA;
`ifdef IMEM_LOADER_CSUM_EN
                        // Checksum byte may land in the final write cycle.
                        if (accept) state_d = (byte_in == xor_q) ? DONE : ERR;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
                if (accept) state_d = (byte_in == xor_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        if (state_d == ERR && state_q != ERR) begin
            err_d  = 1'b1;
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            hold_q  <= HOLD_AT_RESET;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_in    (byte_in),
        .byte_en    (pk_en),
        .word       (word),
        .word_valid (word_valid)
    );

    assign imem_addr = wcnt_q;
    assign imem_data = word;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized loads against a stream-level model.
module tb_imem_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef int          iq_t[$];
    typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_wren;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  ncyc    = 0;
    wr_t wr_q[$];
    int  acc_q[$];
    wr_t mon_w;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_wren  (imem_wren),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always @(negedge clk) begin
        ncyc++;
        if (imem_wren === 1'b1) begin
            mon_w.cyc  = ncyc;
            mon_w.addr = int'(imem_addr);
            mon_w.data = imem_data;
            wr_q.push_back(mon_w);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        start      = with_start;
        while (byte_ready !== 1'b1 && t < 40) begin @(negedge clk); #1; t++; end
        if (byte_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: byte_ready=%b required 1", byte_ready);
        end else begin
            acc_q.push_back(ncyc);
        end
        @(negedge clk); #1;
        byte_valid = 1'b0;
        start      = 1'b0;
        repeat (gap) begin @(negedge clk); #1; end
    endtask

    task automatic stream(input bq_t s, input int gmin, input int gmax, input int st_idx);
        acc_q.delete();
        foreach (s[i]) send_byte(s[i], int'($urandom_range(gmax, gmin)), (i == st_idx));
    endtask

    function automatic bq_t with_csum(input bq_t s);
        bq_t r;
`ifdef IMEM_LOADER_CSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
`endif
        r = s;
`ifdef IMEM_LOADER_CSUM_EN
        r.push_back(x);
`endif
        return r;
    endfunction

    // Reference: word i is bytes 2+4i..5+4i of the stream, first byte lowest;
    // it is written one cycle after its last byte is accepted.
    function automatic void model_writes(input bq_t s, output wq_t w, output iq_t last_idx);
        int n;
        n = int'({s[1], s[0]});
        w.delete();
        last_idx.delete();
        for (int i = 0; i < n; i++) begin
            w.push_back({s[4*i+5], s[4*i+4], s[4*i+3], s[4*i+2]});
            last_idx.push_back(4*i + 5);
        end
    endfunction

    task automatic test_reset();
        idle(3);
        n_tests++;
        if ({byte_ready, imem_wren, load_done, load_err, cpu_hold} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctl: got rdy/wren/done/err/hold=%b required 00001",
                     {byte_ready, imem_wren, load_done, load_err, cpu_hold});
        end
        n_tests++;
        if (imem_addr !== '0 || imem_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%0d data=%h required 0/0", imem_addr, imem_data);
        end
        rst = 1'b0;
        wr_q.delete();
        byte_in = 8'h5A; byte_valid = 1'b1;
        idle(3);
        byte_valid = 1'b0;
        n_tests++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_ignore: got rdy=%b hold=%b writes=%0d required 0/1/0",
                     byte_ready, cpu_hold, wr_q.size());
        end
    endtask

    task automatic test_basic(input string name, input int gap);
        bq_t s; wq_t ew; iq_t ei;
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        s = with_csum(s);
        wr_q.delete();
        pulse_start();
        n_tests++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b1 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: got hold=%b rdy=%b done=%b required 1/1/0",
                     name, cpu_hold, byte_ready, load_done);
        end
        stream(s, gap, gap, -1);
        idle(2);
        model_writes(s, ew, ei);
        n_tests++;
        if (wr_q.size() != ew.size()) begin
            n_fail++;
            $display("FAIL %s_nwr: got %0d writes required %0d", name, wr_q.size(), ew.size());
        end
        foreach (ew[i]) if (i < wr_q.size() && ei[i] < acc_q.size()) begin
            n_tests++;
            if (wr_q[i].addr != i || wr_q[i].data !== ew[i] || wr_q[i].cyc != acc_q[ei[i]] + 1) begin
                n_fail++;
                $display("FAIL %s_wr%0d: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                         name, i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, i, ew[i], acc_q[ei[i]] + 1);
            end
        end
        n_tests++;
        if ({load_done, cpu_hold, load_err, byte_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s_end: got done/hold/err/rdy=%b required 1000",
                     name, {load_done, cpu_hold, load_err, byte_ready});
        end
    endtask

    task automatic test_zero_len();
        bq_t s;
        s = '{8'h00, 8'h00};
        s = with_csum(s);
        wr_q.delete();
        pulse_start();
        stream(s, 0, 0, -1);
        n_tests++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b hold=%b rdy=%b required 1/0/0",
                     load_done, cpu_hold, byte_ready);
        end
        idle(3);
        n_tests++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_nwr: got %0d writes required 0", wr_q.size());
        end
    endtask

    task automatic test_oversize();
        bq_t s;
        s = '{8'h01, 8'h08};
        wr_q.delete();
        pulse_start();
        stream(s, 0, 0, -1);
        n_tests++;
        if ({load_err, byte_ready, cpu_hold, load_done} !== 4'b1010) begin
            n_fail++;
            $display("FAIL over_err: got err/rdy/hold/done=%b required 1010",
                     {load_err, byte_ready, cpu_hold, load_done});
        end
        byte_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin byte_in = 8'($urandom); idle(1); end
        byte_valid = 1'b0;
        n_tests++;
        if (wr_q.size() != 0 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL over_quiet: got writes=%0d err=%b required 0/1", wr_q.size(), load_err);
        end
        pulse_start();
        n_tests++;
        if ({load_err, cpu_hold, byte_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL err_restart: got err/hold/rdy=%b required 011", {load_err, cpu_hold, byte_ready});
        end
        s = '{8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
        stream(s, 0, 0, -1);
        idle(1);
        n_tests++;
        if (load_err !== 1'b0 || byte_ready !== 1'b1 || wr_q.size() != 1 ||
            (wr_q.size() == 1 && (wr_q[0].addr != 0 || wr_q[0].data !== 32'h04030201))) begin
            n_fail++;
            $display("FAIL depth_ok: got err=%b rdy=%b writes=%0d required 0/1/1 (addr 0 = 04030201)",
                     load_err, byte_ready, wr_q.size());
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    task automatic test_reset_midload();
        bq_t s; wq_t ew; iq_t ei;
        wr_q.delete();
        pulse_start();
        s = '{8'h03, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
        stream(s, 0, 0, -1);
        n_tests++;
        if (wr_q.size() != 1 || (wr_q.size() == 1 && (wr_q[0].addr != 0 || wr_q[0].data !== 32'hA3A2A1A0))) begin
            n_fail++;
            $display("FAIL mid_word0: got writes=%0d required 1 (addr 0 = a3a2a1a0)", wr_q.size());
        end
        byte_in = 8'hB1; byte_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({byte_ready, imem_wren, load_done, load_err, cpu_hold} !== 5'b00001 ||
            imem_addr !== '0 || imem_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst: got rdy/wren/done/err/hold=%b addr=%0d data=%h required 00001/0/0",
                     {byte_ready, imem_wren, load_done, load_err, cpu_hold}, imem_addr, imem_data);
        end
        byte_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        n_tests++;
        if (wr_q.size() != 1) begin
            n_fail++;
            $display("FAIL mid_nowr: got %0d writes required 1", wr_q.size());
        end
        wr_q.delete();
        pulse_start();
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        s = with_csum(s);
        stream(s, 0, 1, -1);
        idle(2);
        model_writes(s, ew, ei);
        n_tests++;
        if (wr_q.size() != 1 || (wr_q.size() == 1 && (wr_q[0].addr != 0 || wr_q[0].data !== ew[0] ||
            wr_q[0].data !== 32'hDEADBEEF)) || load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload: got writes=%0d done=%b required 1 write (addr 0 = deadbeef), done=1",
                     wr_q.size(), load_done);
        end
    endtask

    task automatic test_back_to_back();
        bq_t s; wq_t ew; iq_t ei;
        int n, st;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(6, 1));
            s.delete();
            s.push_back(8'(n));
            s.push_back(8'h00);
            for (int k = 0; k < 4*n; k++) s.push_back(8'($urandom));
            st = int'($urandom_range(1 + 4*n, 2));
            s = with_csum(s);
            wr_q.delete();
            pulse_start();
            n_tests++;
            if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_start: got done=%b hold=%b required 0/1", it, load_done, cpu_hold);
            end
            stream(s, 0, 2, st);
            idle(2);
            model_writes(s, ew, ei);
            n_tests++;
            if (wr_q.size() != ew.size() || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_end: got writes=%0d done=%b hold=%b required %0d/1/0",
                         it, wr_q.size(), load_done, cpu_hold, ew.size());
            end
            foreach (ew[i]) if (i < wr_q.size() && ei[i] < acc_q.size()) begin
                n_tests++;
                if (wr_q[i].addr != i || wr_q[i].data !== ew[i] || wr_q[i].cyc != acc_q[ei[i]] + 1) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wr%0d: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                             it, i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, i, ew[i], acc_q[ei[i]] + 1);
                end
            end
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        bq_t s;
        for (int pass = 0; pass < 2; pass++) begin
            s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
            s.push_back(pass == 0 ? 8'h45 : 8'h46);
            wr_q.delete();
            pulse_start();
            stream(s, 0, 0, -1);
            idle(2);
            n_tests++;
            if (wr_q.size() != 1 || (wr_q.size() == 1 && (wr_q[0].addr != 0 || wr_q[0].data !== 32'h44332211))) begin
                n_fail++;
                $display("FAIL csum%0d_wr: got writes=%0d required 1 (addr 0 = 44332211)", pass, wr_q.size());
            end
            n_tests++;
            if ({load_done, load_err, cpu_hold} !== (pass == 0 ? 3'b100 : 3'b011)) begin
                n_fail++;
                $display("FAIL csum%0d_flags: got done/err/hold=%b required %b",
                         pass, {load_done, load_err, cpu_hold}, (pass == 0 ? 3'b100 : 3'b011));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic("basic", 0);
        test_basic("gaps", 3);
        test_zero_len();
        test_oversize();
        test_reset_midload();
        test_back_to_back();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
